// File: rtl/camera_pkg.sv
// Shared types and constants for the camera frame writer: FSM encoding, pixel width, frame size.
package camera_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_NEXT = 2'd3
    } state_e;

    localparam int PIX_W     = 16;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int PIX_CNT_W = 19;
    localparam int CNT_W     = 10;

    function automatic int frame_pix(input int h, input int v);
        return h * v;
    endfunction

    localparam int FRAME_PIX = frame_pix(H_RES_DEF, V_RES_DEF);

endpackage

// File: rtl/fifo_skid_buffer.sv
// 2-entry skid buffer behind a 1-cycle-latency FIFO read; arriving words bypass straight to the output.
// Output holds while out_rdy is low; the caller must throttle pops using count.
module fifo_skid_buffer
    import camera_pkg::*;
(
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [PIX_W-1:0] in_dat,
    output logic             out_vld,
    output logic [PIX_W-1:0] out_dat,
    input  logic             out_rdy,
    output logic [1:0]       count
);

    logic [PIX_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop;

    assign count = cnt_q;

    always_comb begin
        out_vld = (cnt_q != 2'd0) || in_vld;
        out_dat = (cnt_q != 2'd0) ? e0_q : (in_vld ? in_dat : '0);
        pop     = out_vld && out_rdy;
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (in_vld && !out_rdy) begin
                    e0_d  = in_dat;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop) begin
                    if (in_vld) e0_d = in_dat;
                    else        cnt_d = 2'd0;
                end else if (in_vld) begin
                    e1_d  = in_dat;
                    cnt_d = 2'd2;
                end
            end
            default: begin
                // Full: the producer never pops here, so only a drain can occur.
                if (pop) begin
                    e0_d = e1_q;
                    if (in_vld) e1_d = in_dat;
                    else        cnt_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/camera_frame_writer.sv
// Drains the camera pixel FIFO in fixed bursts into a ping-pong frame buffer; req rises 1 cycle after start,
// first word 2 cycles after ack; mem_wr_ready low holds the word and stops pops once the skid is full.
module camera_frame_writer
    import camera_pkg::*;
#(
    parameter int                H_RES     = H_RES_DEF,
    parameter int                V_RES     = V_RES_DEF,
    parameter int                BURST_LEN = 512,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BUF0_BASE = 'h000000,
    parameter logic [ADDR_W-1:0] BUF1_BASE = 'h080000,
    parameter int                OVF_LEVEL = 1020
)(
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [9:0]        fifo_count,
    input  logic [PIX_W-1:0]  fifo_dout,
    output logic              fifo_rd_en,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    input  logic              mem_wr_ack,
    output logic [PIX_W-1:0]  mem_wr_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic              frame_done,
    output logic              front_buf,
    output logic              overflow
);

    localparam int                   FRM_PIX = frame_pix(H_RES, V_RES);
    localparam logic [PIX_CNT_W-1:0] FRM_P   = PIX_CNT_W'(FRM_PIX);
    localparam logic [PIX_CNT_W-1:0] BURST_P = PIX_CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]     BURST_C = CNT_W'(BURST_LEN);
    localparam logic [9:0]           OVF_C   = 10'(OVF_LEVEL);

    state_e                 state_q, state_d;
    logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]       pops_q, pops_d, xfer_q, xfer_d;
    logic                   wr_buf_q, wr_buf_d;
    logic                   front_buf_q, front_buf_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;
    logic                   mem_wr_req_q, mem_wr_req_d;
    logic [ADDR_W-1:0]      mem_wr_addr_q, mem_wr_addr_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [1:0]             skid_cnt;
    logic                   xfer;
    logic                   frame_end;

    fifo_skid_buffer u_skid (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .in_vld  (rd_pend_q),
        .in_dat  (fifo_dout),
        .out_vld (mem_wr_valid),
        .out_dat (mem_wr_data),
        .out_rdy (mem_wr_ready),
        .count   (skid_cnt)
    );

    // Count the in-flight pop as occupied so the skid can never be overrun.
    assign fifo_rd_en = (state_q == ST_DATA) && (pops_q < BURST_C)
                        && ((skid_cnt + {1'b0, rd_pend_q}) < 2'd2);
    assign xfer       = mem_wr_valid && mem_wr_ready;
    assign frame_end  = (pix_cnt_q + BURST_P) == FRM_P;

    assign mem_wr_req  = mem_wr_req_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign frame_done  = frame_done_q;
    assign front_buf   = front_buf_q;
    assign overflow    = overflow_q;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        pops_d        = pops_q;
        xfer_d        = xfer_q;
        wr_buf_d      = wr_buf_q;
        front_buf_d   = front_buf_q;
        frame_done_d  = 1'b0;
        overflow_d    = overflow_q || (fifo_count >= OVF_C);
        mem_wr_req_d  = mem_wr_req_q;
        mem_wr_addr_d = mem_wr_addr_q;
        rd_pend_d     = fifo_rd_en;
        case (state_q)
            ST_IDLE: begin
                if (enable && (fifo_count >= BURST_C)) begin
                    state_d       = ST_REQ;
                    mem_wr_req_d  = 1'b1;
                    mem_wr_addr_d = (wr_buf_q ? BUF1_BASE : BUF0_BASE) + ADDR_W'(pix_cnt_q);
                end
            end
            ST_REQ: begin
                if (mem_wr_ack) begin
                    state_d      = ST_DATA;
                    mem_wr_req_d = 1'b0;
                    pops_d       = '0;
                    xfer_d       = '0;
                end
            end
            ST_DATA: begin
                if (fifo_rd_en) pops_d = pops_q + 1'b1;
                if (xfer) begin
                    xfer_d = xfer_q + 1'b1;
                    if (xfer_q == BURST_C - 1'b1) begin
                        state_d      = ST_NEXT;
                        frame_done_d = frame_end;
                    end
                end
            end
            default: begin
                if (frame_end) begin
                    pix_cnt_d   = '0;
                    front_buf_d = wr_buf_q;
                    wr_buf_d    = ~wr_buf_q;
                end else begin
                    pix_cnt_d   = pix_cnt_q + BURST_P;
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            pops_q        <= '0;
            xfer_q        <= '0;
            wr_buf_q      <= 1'b0;
            front_buf_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            mem_wr_addr_q <= '0;
            rd_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            pops_q        <= pops_d;
            xfer_q        <= xfer_d;
            wr_buf_q      <= wr_buf_d;
            front_buf_q   <= front_buf_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            rd_pend_q     <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Bench for camera_frame_writer with a reduced 64x32 frame (4 bursts of 512 words per frame).
module tb_camera_frame_writer;

    localparam int H   = 64;
    localparam int V   = 32;
    localparam int BL  = 512;
    localparam int FR  = H * V;
    localparam int BPF = FR / BL;
    localparam logic [23:0] B0 = 24'h000000;
    localparam logic [23:0] B1 = 24'h080000;

    logic        clk_100 = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  fifo_count = 10'd0;
    logic [15:0] fifo_dout = 16'd0;
    logic        fifo_rd_en;
    logic        mem_wr_req;
    logic [23:0] mem_wr_addr;
    logic        mem_wr_ack = 1'b0;
    logic [15:0] mem_wr_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b1;
    logic        frame_done;
    logic        front_buf;
    logic        overflow;

    camera_frame_writer #(.H_RES(H), .V_RES(V)) dut (
        .clk_100      (clk_100),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_count   (fifo_count),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_ack   (mem_wr_ack),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .frame_done   (frame_done),
        .front_buf    (front_buf),
        .overflow     (overflow)
    );

    always #5 clk_100 = ~clk_100;

    int total = 0;
    int passed = 0;

    int acc = 0, pops = 0, bursts = 0, fd_cnt = 0, pop_idx = 0, ready_mode = 0;
    logic fd_due = 1'b0, exp_front = 1'b0, ovf_exp = 1'b0, hold_pend = 1'b0;
    logic rd_seen = 1'b0, lat_chk = 1'b0;
    logic [15:0] hold_dat = 16'd0, w0 = 16'd0, w1 = 16'd0;
    logic [23:0] addr_log [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [15:0] pat(input int n);
        int t;
        t = n * 40503 + 7;
        return t[15:0];
    endfunction

    // Burst k since reset: frames alternate buffers, bursts tile each frame linearly.
    function automatic logic [23:0] exp_addr(input int k);
        int f;
        int w;
        f = k / BPF;
        w = k % BPF;
        return ((f % 2) != 0 ? B1 : B0) + 24'(w * BL);
    endfunction

    initial begin
        forever begin
            @(negedge clk_100);
            if (!rst_n) begin
                chk("reset_outputs", {fifo_rd_en, mem_wr_req, mem_wr_valid, frame_done,
                                      front_buf, overflow, |mem_wr_addr, |mem_wr_data}, 32'd0);
                acc = 0; pops = 0; bursts = 0;
                fd_due = 1'b0; exp_front = 1'b0; ovf_exp = 1'b0; hold_pend = 1'b0; rd_seen = 1'b0;
            end else begin
                chk("frame_done", frame_done, fd_due);
                if (frame_done) fd_cnt++;
                chk("front_buf", front_buf, exp_front);
                if (fd_due) exp_front = 1'(((acc / FR) - 1) % 2);
                fd_due = 1'b0;
                chk("overflow", overflow, ovf_exp);
                if (fifo_count >= 10'd1020) ovf_exp = 1'b1;
                if (hold_pend) begin
                    chk("hold_valid", mem_wr_valid, 1);
                    chk("hold_data", mem_wr_data, hold_dat);
                end
                hold_pend = mem_wr_valid && !mem_wr_ready;
                hold_dat  = mem_wr_data;
                if (mem_wr_req && mem_wr_ack) begin
                    chk("burst_addr", mem_wr_addr, exp_addr(bursts));
                    if (bursts < 64) addr_log[bursts] = mem_wr_addr;
                    bursts++;
                end
                if (fifo_rd_en) pops++;
                if (mem_wr_valid && mem_wr_ready) begin
                    chk("word_data", mem_wr_data, pat(acc));
                    if (acc == 0) w0 = mem_wr_data;
                    if (acc == 1) w1 = mem_wr_data;
                    acc++;
                    if (acc % FR == 0) fd_due = 1'b1;
                end
                if (fifo_rd_en || mem_wr_valid) begin
                    chk("outstanding_le2", (pops - acc) <= 2, 1);
                    chk("pops_le_bursts", pops <= bursts * BL, 1);
                end
                rd_seen = fifo_rd_en;
            end
        end
    end

    // FIFO model: a popped word appears on fifo_dout the cycle after fifo_rd_en.
    initial begin
        forever begin
            @(posedge clk_100);
            #1;
            if (!rst_n) pop_idx = 0;
            else if (rd_seen) begin
                fifo_dout = pat(pop_idx);
                pop_idx++;
            end
            mem_wr_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk_100);
            if (mem_wr_req) begin
                repeat (3) @(posedge clk_100);
                #1 mem_wr_ack = 1'b1;
                @(posedge clk_100);
                #1 mem_wr_ack = 1'b0;
                if (lat_chk) begin
                    @(negedge clk_100);
                    chk("lat_rd_en_a1", fifo_rd_en, 1);
                    chk("lat_valid_a1", mem_wr_valid, 0);
                    @(negedge clk_100);
                    chk("lat_valid_a2", mem_wr_valid, 1);
                    lat_chk = 1'b0;
                end
            end
        end
    end

    initial begin
        int nreq;
        fifo_count = 10'd600;
        repeat (3) @(posedge clk_100);
        #1 rst_n = 1'b1;
        @(negedge clk_100);
        chk("idle_no_req", mem_wr_req, 0);

        // Single burst, then stop.
        @(posedge clk_100);
        #1 enable = 1'b1; lat_chk = 1'b1;
        @(negedge clk_100);
        chk("req_before_edge", mem_wr_req, 0);
        @(negedge clk_100);
        chk("req_latency", mem_wr_req, 1);
        chk("t1_addr", mem_wr_addr, 24'h000000);
        @(posedge clk_100);
        #1 enable = 1'b0;
        for (int i = 0; i < 2000 && acc < BL; i++) @(negedge clk_100);
        repeat (20) @(negedge clk_100);
        chk("t1_words", acc, 512);
        chk("t1_pops", pops, 512);
        chk("t1_no_frame_done", fd_cnt, 0);
        chk("t1_word0", w0, 16'h0007);
        chk("t1_word1", w1, 16'h9E3E);

        // Complete the first frame and start the second.
        @(posedge clk_100);
        #1 enable = 1'b1;
        for (int i = 0; i < 8000 && bursts < 5; i++) @(negedge clk_100);
        chk("t2_bursts", bursts >= 5, 1);
        chk("t2_last_addr", addr_log[3], 24'h000600);
        chk("t2_next_addr", addr_log[4], 24'h080000);
        chk("t2_frame_done_once", fd_cnt, 1);
        chk("t2_front_buf", front_buf, 0);

        // Second frame under random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 20000 && bursts < 9; i++) @(negedge clk_100);
        chk("t3_bursts", bursts >= 9, 1);
        chk("t3_buf1_last", addr_log[7], 24'h080600);
        chk("t3_wrap_addr", addr_log[8], 24'h000000);
        chk("t3_frame_done_twice", fd_cnt, 2);
        chk("t3_front_buf", front_buf, 1);
        ready_mode = 0;

        // Overflow is sticky after a single-cycle excursion.
        @(posedge clk_100);
        #1 fifo_count = 10'd1021;
        @(posedge clk_100);
        #1 fifo_count = 10'd600;
        repeat (5) @(negedge clk_100);
        chk("ovf_sticky", overflow, 1);

        // Reset in the middle of a burst.
        for (int i = 0; i < 3000 && !mem_wr_valid; i++) @(negedge clk_100);
        chk("in_data_before_reset", mem_wr_valid, 1);
        @(posedge clk_100);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_outputs", {fifo_rd_en, mem_wr_req, mem_wr_valid, frame_done,
                                     front_buf, overflow, |mem_wr_addr, |mem_wr_data}, 32'd0);
        repeat (3) @(posedge clk_100);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100 && bursts < 1; i++) @(negedge clk_100);
        chk("restart_addr", addr_log[0], 24'h000000);

        // Drop enable during the third burst.
        for (int i = 0; i < 5000 && bursts < 3; i++) @(negedge clk_100);
        @(posedge clk_100);
        #1 enable = 1'b0;
        for (int i = 0; i < 3000 && acc < 3 * BL; i++) @(negedge clk_100);
        chk("t5_burst_completed", acc, 3 * BL);
        nreq = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_100);
            if (mem_wr_req) nreq++;
        end
        chk("t5_no_req_disabled", nreq, 0);
        chk("t5_bursts_held", bursts, 3);
        @(posedge clk_100);
        #1 enable = 1'b1;
        for (int i = 0; i < 200 && bursts < 4; i++) @(negedge clk_100);
        chk("t5_resume_addr", addr_log[3], 24'h000600);
        repeat (10) @(negedge clk_100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
